// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the CPU memory stage and the byte-addressed
// data memory. It range-checks each request and issues one native-size memory
// transaction for an aligned access. Load results are assembled little-endian
// and zero- or sign-extended. The result is returned as a one-cycle pulse.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN. When it is defined, misaligned
// half/word accesses run as a sequence of byte transactions. When it is not
// defined, misaligned half/word accesses are rejected with resp_err.
module lsu_ctrl #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  mem_write,
  output logic [2:0]  mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2, S_SPLIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        sgn_q, sgn_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  last_q, last_d;
`endif

  logic [2:0]  req_n;
  logic [32:0] req_end;
  logic        range_err;
  logic        misal;
  logic        bad;

  // Memory size encoding: byte 11, half 10, word 01.
  function automatic logic [1:0] size_code(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b11;
      2'b01:   return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  // Acceptance-time checks. The end address is computed in 33 bits so that a
  // request near 2^32 cannot wrap around and pass the range check.
  always_comb begin
    req_n     = (req_size == 2'b10) ? 3'd4 : (req_size == 2'b01) ? 3'd2 : 3'd1;
    req_end   = {1'b0, req_addr} + {30'b0, req_n};
    range_err = req_end > 33'(MEM_BYTES);
    misal     = ((req_size == 2'b01) && req_addr[0]) ||
                ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
    bad       = (req_size == 2'b11) || range_err;
`else
    bad       = (req_size == 2'b11) || range_err || misal;
`endif
  end

  // Next-state logic and outputs. mem_addr and mem_wdata hold their last
  // driven value while the unit is idle or responding.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    we_d       = we_q;
    sgn_d      = sgn_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    maddr_d    = maddr_q;
    mwdata_d   = mwdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    cnt_d      = cnt_q;
    last_d     = last_q;
`endif
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    mem_write  = 2'b00;
    mem_read   = 3'b000;
    mem_addr   = maddr_q;
    mem_wdata  = mwdata_q;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          sgn_d   = req_signed;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          err_d   = bad;
          if (bad) begin
            state_d = S_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
          end else if (misal) begin
            cnt_d   = 2'd0;
            last_d  = (req_size == 2'b10) ? 2'd3 : 2'd1;
            state_d = S_SPLIT;
`endif
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        mem_addr = addr_q;
        if (we_q) begin
          mem_write = size_code(size_q);
          mem_wdata = wdata_q;
        end else begin
          mem_read = {1'b0, size_code(size_q)};
          rdata_d  = mem_rdata;
        end
        maddr_d  = mem_addr;
        mwdata_d = mem_wdata;
        state_d  = S_RESP;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      S_SPLIT: begin
        mem_addr = addr_q + {30'b0, cnt_q};
        if (we_q) begin
          mem_write = 2'b11;
          mem_wdata = {24'h0, wdata_q[{cnt_q, 3'b000} +: 8]};
        end else begin
          mem_read = 3'b011;
          rdata_d[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
        end
        maddr_d  = mem_addr;
        mwdata_d = mem_wdata;
        if (cnt_q == last_q) state_d = S_RESP;
        else                 cnt_d   = cnt_q + 2'd1;
      end
`endif
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q && !we_q) begin
          case (size_q)
            2'b00:   resp_rdata = sgn_q ? {{24{rdata_q[7]}}, rdata_q[7:0]} : {24'h0, rdata_q[7:0]};
            2'b01:   resp_rdata = sgn_q ? {{16{rdata_q[15]}}, rdata_q[15:0]} : {16'h0, rdata_q[15:0]};
            default: resp_rdata = rdata_q;
          endcase
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // While reset is high, suppress the transaction of the cycle being
    // aborted, so a partial split store stops at the bytes already committed.
    if (reset) begin
      mem_write  = 2'b00;
      mem_read   = 3'b000;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'h0;
    end
  end

  // State and request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0;
      size_q   <= 2'b00;
      we_q     <= 1'b0;
      sgn_q    <= 1'b0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cnt_q    <= 2'd0;
      last_q   <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      we_q     <= we_d;
      sgn_q    <= sgn_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      cnt_q    <= cnt_d;
      last_q   <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: byte-array data memory, directed scenarios and a
// randomized run scored against a byte-level reference memory.
module tb_lsu_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_write;
  logic [2:0]  mem_read;

  int ncmp = 0;
  int nfail = 0;

  logic [7:0]  mem [0:127];
  logic [7:0]  ref_mem [0:127];
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [1:0]  wq_code[$];

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  lsu_ctrl #(.MEM_BYTES(128)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 128; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end

  // Memory write port: commits at posedge, logs every write transaction.
  always @(posedge clk) begin
    int n;
    if (mem_write != 2'b00) begin
      n = (mem_write == 2'b01) ? 4 : (mem_write == 2'b10) ? 2 : 1;
      for (int k = 0; k < n; k++)
        if (mem_addr + 32'(k) < 32'd128) mem[7'(mem_addr + 32'(k))] = mem_wdata[8*k +: 8];
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
      wq_code.push_back(mem_write);
    end
  end

  // Memory read port: combinational.
  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = (mem_addr < 32'd128)          ? mem[7'(mem_addr)]          : 8'h00;
    b1 = (mem_addr + 32'd1 < 32'd128)  ? mem[7'(mem_addr + 32'd1)]  : 8'h00;
    b2 = (mem_addr + 32'd2 < 32'd128)  ? mem[7'(mem_addr + 32'd2)]  : 8'h00;
    b3 = (mem_addr + 32'd3 < 32'd128)  ? mem[7'(mem_addr + 32'd3)]  : 8'h00;
    mem_rdata = 32'h0;
    case (mem_read[1:0])
      2'b01: mem_rdata = {b3, b2, b1, b0};
      2'b10: mem_rdata = mem_read[2] ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
      2'b11: mem_rdata = mem_read[2] ? {{24{b0[7]}}, b0} : {24'h0, b0};
      default: mem_rdata = 32'h0;
    endcase
  end

  // Reference: little-endian assembly from the reference memory plus extension.
  function automatic logic [31:0] ref_load(int a, logic [1:0] sz, logic sg);
    int n;
    logic [31:0] v;
    n = (sz == 2'b10) ? 4 : (sz == 2'b01) ? 2 : 1;
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
    if (sz == 2'b00 && sg && v[7])  v = v | 32'hFFFFFF00;
    if (sz == 2'b01 && sg && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  // Issue one request and wait (bounded) for its response.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input bit junk,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int nwr, output int nrd);
    bit got, busy_bad;
    @(negedge clk);
    ncmp++;
    if (req_ready !== 1'b1) begin nfail++; $display("FAIL ready_idle: got %b want 1", req_ready); end
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    wq_addr.delete(); wq_data.delete(); wq_code.delete();
    @(posedge clk); #1;
    if (junk) begin
      req_we = $urandom_range(0, 1); req_size = 2'($urandom_range(0, 3));
      req_addr = $urandom_range(0, 127); req_wdata = $urandom;
    end else req_valid = 1'b0;
    got = 0; busy_bad = 0; lat = 0; nwr = 0; nrd = 0; rd = 32'hx; er = 1'bx;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_write != 2'b00) nwr++;
      if (mem_read != 3'b000) nrd++;
      if (resp_valid === 1'b1) begin got = 1; rd = resp_rdata; er = resp_err; end
      else if (req_ready !== 1'b0) busy_bad = 1;
    end
    req_valid = 1'b0;
    ncmp++;
    if (!got) begin nfail++; $display("FAIL resp_timeout: no resp_valid within %0d cycles", lat); end
    ncmp++;
    if (busy_bad) begin nfail++; $display("FAIL ready_busy: req_ready high while busy, want 0"); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    ncmp++;
    if ({req_ready, resp_valid, resp_err} !== 3'b100 || resp_rdata !== 32'h0) begin
      nfail++; $display("FAIL reset_resp: ready/valid/err=%b rdata=%h want 100/0", {req_ready, resp_valid, resp_err}, resp_rdata);
    end
    ncmp++;
    if (mem_write !== 2'b00 || mem_read !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      nfail++; $display("FAIL reset_mem: w=%b r=%b a=%h d=%h want all 0", mem_write, mem_read, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_aligned();
    logic [31:0] rd; logic er; int lat, nwr, nrd;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat, nwr, nrd);
    ncmp++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'h0) begin nfail++; $display("FAIL st_word: lat=%0d err=%b rd=%h want 2/0/0", lat, er, rd); end
    ncmp++;
    if (wq_code.size() != 1 || wq_code[0] !== 2'b01 || wq_addr[0] !== 32'h10 || wq_data[0] !== 32'hDEADBEEF) begin
      nfail++; $display("FAIL st_word_txn: nwrites=%0d want one word write of DEADBEEF @10", wq_code.size());
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, nwr, nrd);
    ncmp++;
    if (lat != 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || nrd != 1) begin
      nfail++; $display("FAIL ld_word: lat=%0d err=%b rd=%h nrd=%0d want 2/0/DEADBEEF/1", lat, er, rd, nrd);
    end
  endtask

  task automatic test_extend();
    logic [31:0] rd; logic er; int lat, nwr, nrd;
    do_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h00000080, 1'b0, rd, er, lat, nwr, nrd);
    do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 1'b0, rd, er, lat, nwr, nrd);
    ncmp++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin nfail++; $display("FAIL ld_sbyte: rd=%h want FFFFFF80", rd); end
    do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 1'b0, rd, er, lat, nwr, nrd);
    ncmp++;
    if (rd !== 32'h00000080) begin nfail++; $display("FAIL ld_ubyte: rd=%h want 00000080", rd); end
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h00008001, 1'b0, rd, er, lat, nwr, nrd);
    do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, rd, er, lat, nwr, nrd);
    ncmp++;
    if (rd !== 32'hFFFF8001 || lat != 2) begin nfail++; $display("FAIL ld_shalf: rd=%h lat=%0d want FFFF8001/2", rd, lat); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat, nwr, nrd;
    if (SPLIT) begin
      do_req(1'b1, 2'b10, 1'b0, 32'h05, 32'h11223344, 1'b0, rd, er, lat, nwr, nrd);
      ncmp++;
      if (lat != 5 || er !== 1'b0 || wq_code.size() != 4) begin
        nfail++; $display("FAIL split_st: lat=%0d err=%b nwrites=%0d want 5/0/4", lat, er, wq_code.size());
      end else begin
        for (int k = 0; k < 4; k++) begin
          logic [31:0] wd;
          wd = 32'h11223344 >> (8 * k);
          ncmp++;
          if (wq_code[k] !== 2'b11 || wq_addr[k] !== 32'(5 + k) || wq_data[k][7:0] !== wd[7:0]) begin
            nfail++; $display("FAIL split_st_byte%0d: code=%b addr=%h data=%h want 11/%h/%h", k, wq_code[k], wq_addr[k], wq_data[k][7:0], 5 + k, wd[7:0]);
          end
        end
      end
      do_req(1'b0, 2'b10, 1'b0, 32'h05, 32'h0, 1'b0, rd, er, lat, nwr, nrd);
      ncmp++;
      if (lat != 5 || rd !== 32'h11223344 || nrd != 4) begin
        nfail++; $display("FAIL split_ld: lat=%0d rd=%h nrd=%0d want 5/11223344/4", lat, rd, nrd);
      end
    end else begin
      do_req(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1'b0, rd, er, lat, nwr, nrd);
      ncmp++;
      if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || nrd != 0) begin
        nfail++; $display("FAIL misal_err: lat=%0d err=%b rd=%h nrd=%0d want 1/1/0/0", lat, er, rd, nrd);
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er; int lat, nwr, nrd;
    do_req(1'b0, 2'b10, 1'b0, 32'h7E, 32'h0, 1'b0, rd, er, lat, nwr, nrd);
    ncmp++;
    if (er !== 1'b1 || lat != 1 || nrd != 0 || rd !== 32'h0) begin nfail++; $display("FAIL range_7e: err=%b lat=%0d nrd=%0d want 1/1/0", er, lat, nrd); end
    do_req(1'b1, 2'b11, 1'b0, 32'h04, 32'h12345678, 1'b0, rd, er, lat, nwr, nrd);
    ncmp++;
    if (er !== 1'b1 || lat != 1 || nwr != 0) begin nfail++; $display("FAIL size11: err=%b lat=%0d nwr=%0d want 1/1/0", er, lat, nwr); end
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0, 1'b0, rd, er, lat, nwr, nrd);
    ncmp++;
    if (er !== 1'b1 || nwr != 0) begin nfail++; $display("FAIL range_wrap: err=%b nwr=%0d want 1/0", er, nwr); end
    do_req(1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 1'b0, rd, er, lat, nwr, nrd);
    ncmp++;
    if (er !== 1'b0 || lat != 2 || nrd != 1) begin nfail++; $display("FAIL range_7c: err=%b lat=%0d want 0/2", er, lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat, nwr, nrd;
    do_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 1'b1, rd, er, lat, nwr, nrd);
    ncmp++;
    if (nwr != 1 || lat != 2) begin nfail++; $display("FAIL b2b_st: nwr=%0d lat=%0d want 1/2", nwr, lat); end
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1, rd, er, lat, nwr, nrd);
    ncmp++;
    if (rd !== 32'hCAFEF00D || nwr != 0) begin nfail++; $display("FAIL b2b_ld: rd=%h nwr=%0d want CAFEF00D/0", rd, nwr); end
  endtask

  task automatic test_reset_mid();
    bit seen_resp, seen_txn;
    logic [31:0] a;
    a = SPLIT ? 32'h01 : 32'h40;
    @(negedge clk);
    for (int k = 0; k < 4; k++) mem[7'(a) + 7'(k)] = 8'h5A;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = a; req_wdata = 32'hA4A3A2A1;
    @(posedge clk); #1 req_valid = 1'b0;
    if (SPLIT) repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    ncmp++;
    if (req_ready !== 1'b1) begin nfail++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
    seen_resp = 0; seen_txn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen_resp = 1;
      if (mem_write !== 2'b00 || mem_read !== 3'b000) seen_txn = 1;
    end
    ncmp++;
    if (seen_resp || seen_txn) begin nfail++; $display("FAIL rst_mid_quiet: resp=%0d txn=%0d want 0/0", seen_resp, seen_txn); end
    ncmp++;
    if (SPLIT) begin
      if ({mem[1], mem[2], mem[3], mem[4]} !== 32'hA1A25A5A) begin
        nfail++; $display("FAIL rst_mid_mem: bytes1..4=%h %h %h %h want A1 A2 5A 5A", mem[1], mem[2], mem[3], mem[4]);
      end
    end else if ({mem[64], mem[65], mem[66], mem[67]} !== 32'h5A5A5A5A) begin
      nfail++; $display("FAIL rst_mid_mem: bytes40..43=%h %h %h %h want 5A x4", mem[64], mem[65], mem[66], mem[67]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, wd; logic er, exp_er, we, sg; logic [1:0] sz;
    int lat, nwr, nrd, a, n, exp_lat, exp_acc, bad_mem;
    bit mis;
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      mem[i] = v; ref_mem[i] = v;
    end
    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = $urandom_range(0, 135);
      wd = $urandom;
      n  = (sz == 2'b10) ? 4 : (sz == 2'b01) ? 2 : 1;
      mis = (a % n) != 0;
      exp_er  = (sz == 2'b11) || (a + n > 128) || (mis && !SPLIT);
      exp_lat = exp_er ? 1 : mis ? n + 1 : 2;
      exp_acc = exp_er ? 0 : mis ? n : 1;
      exp_rd  = 32'h0;
      if (!exp_er) begin
        if (we) for (int k = 0; k < n; k++) ref_mem[a + k] = wd[8*k +: 8];
        else    exp_rd = ref_load(a, sz, sg);
      end
      do_req(we, sz, sg, 32'(a), wd, 1'(t % 2), rd, er, lat, nwr, nrd);
      ncmp++;
      if (er !== exp_er || rd !== exp_rd) begin
        nfail++; $display("FAIL rnd_resp[%0d]: we=%b sz=%b a=%0d err=%b rd=%h want %b/%h", t, we, sz, a, er, rd, exp_er, exp_rd);
      end
      ncmp++;
      if (lat != exp_lat) begin nfail++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", t, lat, exp_lat); end
      ncmp++;
      if (nwr != (we ? exp_acc : 0) || nrd != (we ? 0 : exp_acc)) begin
        nfail++; $display("FAIL rnd_txn[%0d]: nwr=%0d nrd=%0d want %0d/%0d", t, nwr, nrd, we ? exp_acc : 0, we ? 0 : exp_acc);
      end
    end
    bad_mem = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad_mem++;
    ncmp++;
    if (bad_mem != 0) begin nfail++; $display("FAIL rnd_mem: %0d bytes differ, want 0", bad_mem); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_extend();
    test_misalign();
    test_range();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
